// File: rtl/baud_tick_gen.sv
// Fractional baud tick generator: os/mid/bit strobes from clk50MHz.
// Ports: clk50MHz, rst_n, en, restart, rate_sel -> os_tick, mid_tick, bit_tick, os_idx
//   (BAUD_CLK_OUT_EN adds baud_clk, a toggle at every os_tick).
module baud_tick_gen #(
  parameter longint unsigned CLK_HZ     = 50_000_000,
  parameter int              OVERSAMPLE = 16,
  parameter int              ACC_W      = 24,
  parameter longint unsigned BAUD0      = 9600,
  parameter longint unsigned BAUD1      = 19200,
  parameter longint unsigned BAUD2      = 57600,
  parameter longint unsigned BAUD3      = 115200
) (
  input  logic                          clk50MHz,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic                          restart,
  input  logic [1:0]                    rate_sel,
  output logic                          os_tick,
  output logic                          mid_tick,
  output logic                          bit_tick,
`ifdef BAUD_CLK_OUT_EN
  output logic                          baud_clk,
`endif
  output logic [$clog2(OVERSAMPLE)-1:0] os_idx
);

  localparam int IDX_W = $clog2(OVERSAMPLE);

  function automatic logic [ACC_W-1:0] inc_of(
    input longint unsigned baud
  );
    longint unsigned num;
    num = baud * longint'(OVERSAMPLE) * (64'd1 << ACC_W);
    return ACC_W'((num + CLK_HZ / 2) / CLK_HZ);
  endfunction

  localparam logic [ACC_W-1:0] INC0 = inc_of(BAUD0);
  localparam logic [ACC_W-1:0] INC1 = inc_of(BAUD1);
  localparam logic [ACC_W-1:0] INC2 = inc_of(BAUD2);
  localparam logic [ACC_W-1:0] INC3 = inc_of(BAUD3);

  localparam logic [IDX_W-1:0] MID_IDX = IDX_W'(OVERSAMPLE / 2 - 1);
  localparam logic [IDX_W-1:0] END_IDX = IDX_W'(OVERSAMPLE - 1);

  logic             run_q;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] inc_active;
  logic [ACC_W-1:0] inc_sel;
  logic [ACC_W:0]   sum;
  logic             carry;

  always_comb begin
    inc_sel = INC0;
    unique case (rate_sel)
      2'd0: inc_sel = INC0;
      2'd1: inc_sel = INC1;
      2'd2: inc_sel = INC2;
      2'd3: inc_sel = INC3;
      default: inc_sel = INC0;
    endcase
  end

  assign sum   = {1'b0, acc} + {1'b0, inc_active};
  assign carry = sum[ACC_W];

  // os_idx is the index of the tick being shown,
  // so the strobes are plain decodes of the same cycle.
  assign mid_tick = os_tick & (os_idx == MID_IDX);
  assign bit_tick = os_tick & (os_idx == END_IDX);

  // Release of rst_n is retimed: counting begins one
  // clock after this flop goes high.
  always_ff @(posedge clk50MHz or negedge rst_n) begin
    if (!rst_n) run_q <= 1'b0;
    else        run_q <= 1'b1;
  end

  always_ff @(posedge clk50MHz or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      inc_active <= INC0;
      os_idx     <= '0;
      os_tick    <= 1'b0;
    end else if (restart) begin
      acc        <= '0;
      inc_active <= inc_sel;
      os_idx     <= '0;
      os_tick    <= 1'b0;
    end else begin
      // A tick already shown is always booked,
      // even if en drops in that same cycle.
      if (os_tick)
        os_idx <= os_idx + 1'b1;
      if (bit_tick)
        inc_active <= inc_sel;
      if (en && run_q) begin
        acc     <= sum[ACC_W-1:0];
        os_tick <= carry & ~os_tick;
      end else begin
        os_tick <= 1'b0;
      end
    end
  end

`ifdef BAUD_CLK_OUT_EN
  always_ff @(posedge clk50MHz or negedge rst_n) begin
    if (!rst_n)       baud_clk <= 1'b0;
    else if (restart) baud_clk <= 1'b0;
    else if (os_tick) baud_clk <= ~baud_clk;
  end
`endif

endmodule

// File: tb/tb_baud_tick_gen.sv
// Directed bench for baud_tick_gen at default parameters.
// Covers reset, phase, gaps, rate switch, enable, restart.
module tb_baud_tick_gen;

  logic       clk50MHz = 1'b0;
  logic       rst_n;
  logic       en;
  logic       restart;
  logic [1:0] rate_sel;
  logic       os_tick;
  logic       mid_tick;
  logic       bit_tick;
  logic [3:0] os_idx;
`ifdef BAUD_CLK_OUT_EN
  logic       baud_clk;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  baud_tick_gen dut (
    .clk50MHz (clk50MHz),
    .rst_n    (rst_n),
    .en       (en),
    .restart  (restart),
    .rate_sel (rate_sel),
    .os_tick  (os_tick),
    .mid_tick (mid_tick),
    .bit_tick (bit_tick),
`ifdef BAUD_CLK_OUT_EN
    .baud_clk (baud_clk),
`endif
    .os_idx   (os_idx)
  );

  always #10 clk50MHz = ~clk50MHz;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk50MHz);
    #1;
  endtask

  // Clocks until the next os_tick is seen (bounded).
  task automatic wait_tick(output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!os_tick && n < 2000);
    if (!os_tick) chk("tick_timeout", 0, 1);
  endtask

  task automatic do_restart();
    restart = 1'b1;
    cyc();
    restart = 1'b0;
  endtask

  int n;
  int bad;
  int os_cnt, mid_cnt, bit_cnt;

  initial begin
    rst_n    = 1'b0;
    en       = 1'b0;
    restart  = 1'b0;
    rate_sel = 2'd0;
    #25;
    chk("rst_os",  32'(os_tick),  0);
    chk("rst_mid", 32'(mid_tick), 0);
    chk("rst_bit", 32'(bit_tick), 0);
    chk("rst_idx", 32'(os_idx),   0);

    // Release: 1 sync clock, then tick at counting edge 326.
    cyc();
    rst_n = 1'b1;
    en    = 1'b1;
    wait_tick(n);
    chk("rel_first", n, 327);
    chk("rel_idx", 32'(os_idx), 0);

    // Restart phase and gap pattern at 9600.
    do_restart();
    chk("rs_os",  32'(os_tick), 0);
    chk("rs_idx", 32'(os_idx),  0);
`ifdef BAUD_CLK_OUT_EN
    chk("rs_bclk", 32'(baud_clk), 0);
`endif
    wait_tick(n);
    chk("rs_first", n, 326);
`ifdef BAUD_CLK_OUT_EN
    cyc();
    chk("bclk_tog", 32'(baud_clk), 1);
`endif
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      wait_tick(n);
      if (n != 325 && n != 326) bad++;
    end
    chk("gap_r0", bad, 0);

    // 20000 counting cycles: floor(20000*51540/2^24)=61.
    do_restart();
    os_cnt = 0; mid_cnt = 0; bit_cnt = 0;
    for (int i = 0; i < 20000; i++) begin
      cyc();
      os_cnt  += int'(os_tick);
      mid_cnt += int'(mid_tick);
      bit_cnt += int'(bit_tick);
    end
    chk("cnt_os",  os_cnt,  61);
    chk("cnt_mid", mid_cnt, 4);
    chk("cnt_bit", bit_cnt, 3);

    // Freeze after 1000 counting edges (ticks at 326,652,977).
    do_restart();
    os_cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      cyc();
      os_cnt += int'(os_tick);
    end
    chk("frz_pre", os_cnt, 3);
    en = 1'b0;
    os_cnt = 0;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      cyc();
      os_cnt += int'(os_tick);
      if (os_idx != 4'd3) bad++;
    end
    chk("frz_ticks", os_cnt, 0);
    chk("frz_idx",   bad,    0);
    en = 1'b1;
    wait_tick(n);
    chk("frz_resume", n, 303);

    // Rate change mid-bit takes effect only after bit_tick.
    do_restart();
    for (int i = 0; i < 3; i++) wait_tick(n);
    rate_sel = 2'd3;
    bad = 0;
    os_cnt = 0;
    do begin
      wait_tick(n);
      os_cnt++;
      if (n != 325 && n != 326) bad++;
    end while (!bit_tick && os_cnt < 20);
    chk("rc_old_gaps", bad, 0);
    chk("rc_ticks",    os_cnt, 13);
    wait_tick(n);
    chk("rc_wrap_idx", 32'(os_idx), 0);
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      wait_tick(n);
      if (n != 27 && n != 28) bad++;
    end
    chk("rc_new_gaps", bad, 0);

    // Restart coinciding with carry drops that tick.
    rate_sel = 2'd0;
    do_restart();
    repeat (325) cyc();
    restart = 1'b1;
    cyc();
    chk("rc_carry_os",  32'(os_tick), 0);
    chk("rc_carry_idx", 32'(os_idx),  0);
    restart = 1'b0;
    wait_tick(n);
    chk("rc_carry_nxt", n, 326);

    // Async reset during a tick clears outputs at once.
    wait_tick(n);
    chk("pre_rst_idx", 32'(os_idx), 1);
    rst_n = 1'b0;
    #1;
    chk("arst_os",  32'(os_tick),  0);
    chk("arst_bit", 32'(bit_tick), 0);
    chk("arst_idx", 32'(os_idx),   0);
    #20;
    rst_n = 1'b1;
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
